eth_tx_framer: RTL
==================

Name: eth_tx_framer

Overview:
- Ethernet MAC transmit framer; sits between the UDP/IP packet builder and the GMII-style byte output.
- Accepts a frame body (DA through payload) as a byte stream and emits, in order: preamble, SFD, body, zero padding to the minimum length, FCS, then an inter-frame gap.
- Drives an external CRC-32 engine (reflected 0xEDB88320, init 0xFFFFFFFF, one byte per enable) and reads its register back to form the FCS.

Parameters:
- MIN_BODY, 60, minimum body bytes before FCS; shorter bodies are zero-padded. Legal range 0..60.
- MAX_BODY, 1514, maximum body bytes; exceeding this is an error.
- IFG_BYTES, 12, idle cycles after the last FCS byte. Minimum 1.

Ports:
- clk  in  1  clock, one byte per cycle
- rst  in  1  reset, synchronous, active-high
- s_data  in  8  body byte
- s_valid  in  1  s_data valid
- s_last  in  1  marks the last body byte
- s_ready  out  1  framer accepts a byte when s_valid && s_ready
- crc_clr  out  1  to CRC engine: load 0xFFFFFFFF
- crc_en  out  1  to CRC engine: consume crc_din this cycle
- crc_din  out  8  to CRC engine: byte to consume
- crc_in  in  32  CRC engine register, pre-inversion, updated one cycle after crc_en
- gmii_txd  out  8  registered output byte
- gmii_tx_en  out  1  registered, high for preamble through FCS
- gmii_tx_er  out  1  registered error flag
- frame_done  out  1  one-cycle pulse when the last FCS byte is on gmii_txd
- underrun  out  1  one-cycle pulse on an underrun or oversize abort

Behaviour:
- Reset: state IDLE; gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, crc_clr=0, crc_en=0, frame_done=0, underrun=0; all counters cleared. Reset mid-frame aborts immediately with no FCS and no IFG.
- Output registers load from the current-state decode, so each byte appears on gmii_txd one cycle after its state cycle.
- State sequence:
  - IDLE: gmii_tx_en=0. If s_valid=1, go to PRE. The byte is not consumed.
  - PRE: 7 cycles, each outputting 0x55.
  - SFD: 1 cycle outputting 0xD5; crc_clr=1 this cycle. Body count cleared.
  - DATA: s_ready=1.
    - On an accepted byte: output s_data, crc_en=1, crc_din=s_data, body count +1.
    - If the accepted byte has s_last=1: go to PAD if body count < MIN_BODY, else go to FCS.
    - If s_valid=0 in DATA: underrun. Output 0x00 with gmii_tx_er=1 and gmii_tx_en=1 for that cycle, pulse underrun, go to DRAIN.
    - If body count would exceed MAX_BODY: same abort path as an underrun.
  - PAD: output 0x00 with crc_en=1, crc_din=0x00, until body count = MIN_BODY; then go to FCS.
  - FCS: 4 cycles.
    - On the first cycle, latch fcs = ~crc_in. crc_in is valid here because the last crc_en was one cycle earlier.
    - Output fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24] in that order.
    - frame_done is asserted with the 4th FCS byte on the output.
  - IFG: IFG_BYTES cycles with gmii_tx_en=0, then return to IDLE. s_ready=0 during IFG.
  - DRAIN: s_ready=1, gmii_tx_en=0. Discard bytes until an accepted byte has s_last=1, then go to IFG. If the offending byte itself had s_last=1, go straight to IFG.
- crc_en is never asserted outside DATA and PAD. crc_clr is asserted only in SFD.
- Body counter is 11 bits; saturation is not needed because of the MAX_BODY check.
- s_ready is combinational from the state (DATA or DRAIN only). s_data is ignored while s_ready=0.
- Wire length of a good frame: gmii_tx_en high for 8 + max(body, MIN_BODY) + 4 cycles.
- Back-to-back frames: the next frame's PRE starts no earlier than IFG_BYTES idle cycles after the last FCS byte.

Test Plan:
- MIN_BODY=0; body ASCII "123456789" sent contiguously -> 55×7, D5, 31..39, then FCS bytes 26 39 F4 CB; tx_en high for 21 cycles; frame_done high with CB.
- Default params; 14-byte body -> 46 zero pad bytes; tx_en high for 72 cycles; FCS matches a software CRC-32 of body plus pad.
- s_valid dropped after 20 accepted bytes of a 64-byte frame -> one byte 00 with tx_er=1 and an underrun pulse; rest discarded until s_last; no FCS; 12 idle cycles; next frame clean.
- 1515-byte body -> abort at byte 1515 with tx_er=1 and underrun=1; remaining input drained.
- Two 64-byte frames offered back-to-back -> exactly 12 cycles with tx_en=0 between the last FCS byte and the next 0x55.
- rst asserted mid-DATA -> next cycle all outputs at reset values; s_ready=0; following frame transmits correctly.

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// Byte-stream handshake from the UDP/IP packet builder into the MAC transmit framer.
interface eth_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet MAC transmit framer: preamble, SFD, body, zero pad, FCS, inter-frame gap.
// The CRC-32 engine is external; this block sequences it and reads back its register.
//
// state | meaning
// IDLE  | no frame in progress, waiting for s_valid
// PRE   | 7 preamble bytes (0x55)
// SFD   | start-of-frame delimiter (0xD5), CRC engine cleared
// DATA  | body bytes passed through and fed to the CRC engine
// PAD   | zero bytes until the minimum body length is reached
// FCS   | 4 inverted-CRC bytes, LSB first
// IFG   | gmii_tx_en low for the inter-frame gap
// DRAIN | aborted frame, discard input up to s_last
module eth_tx_framer #(
  parameter int MIN_BODY  = 60,
  parameter int MAX_BODY  = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_tx_framer_if.slave         s,
  output logic                   crc_clr,
  output logic                   crc_en,
  output logic [7:0]             crc_din,
  input  logic [31:0]            crc_in,
  output logic [7:0]             gmii_txd,
  output logic                   gmii_tx_en,
  output logic                   gmii_tx_er,
  output logic                   frame_done,
  output logic                   underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN} state_t;

  localparam logic [10:0] MIN_B    = 11'(MIN_BODY);
  localparam logic [10:0] MAX_B    = 11'(MAX_BODY);
  localparam logic [15:0] PRE_LAST = 16'd6;
  localparam logic [15:0] FCS_LAST = 16'd3;
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  state_t      state_q;
  logic [15:0] tmr_q;
  logic [10:0] body_q;
  logic [10:0] body_d;
  logic [23:0] fcs_q;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        done_q;
  logic        urun_q;

  // Handshake and CRC-engine strobes decode straight from the current state so the
  // engine register has absorbed the last body/pad byte by the first FCS cycle.
  always_comb begin
    s.s_ready = (state_q == DATA) || (state_q == DRAIN);
    body_d    = body_q + 11'd1;
    crc_clr   = (state_q == SFD);
    crc_en    = ((state_q == DATA) && s.s_valid) || (state_q == PAD);
    crc_din   = (state_q == DATA) ? s.s_data : 8'h00;
  end

  // Framing FSM; output registers load from the current-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      body_q  <= '0;
      fcs_q   <= '0;
      txd_q   <= 8'h00;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      txd_q   <= 8'h00;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s.s_valid) begin
            state_q <= PRE;
            tmr_q   <= PRE_LAST;
          end
        end
        PRE: begin
          txd_q   <= 8'h55;
          tx_en_q <= 1'b1;
          if (tmr_q == 16'd0) state_q <= SFD;
          else                tmr_q   <= tmr_q - 16'd1;
        end
        SFD: begin
          txd_q   <= 8'hD5;
          tx_en_q <= 1'b1;
          body_q  <= '0;
          state_q <= DATA;
        end
        DATA: begin
          tx_en_q <= 1'b1;
          if (!s.s_valid || (body_q == MAX_B)) begin
            // underrun or oversize: one errored byte, then discard the rest
            tx_er_q <= 1'b1;
            urun_q  <= 1'b1;
            if (s.s_valid && s.s_last) begin
              state_q <= IFG;
              tmr_q   <= IFG_LAST;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            txd_q  <= s.s_data;
            body_q <= body_d;
            if (s.s_last) begin
              if (body_d < MIN_B) begin
                state_q <= PAD;
              end else begin
                state_q <= FCS;
                tmr_q   <= FCS_LAST;
              end
            end
          end
        end
        PAD: begin
          tx_en_q <= 1'b1;
          body_q  <= body_d;
          if (body_d >= MIN_B) begin
            state_q <= FCS;
            tmr_q   <= FCS_LAST;
          end
        end
        FCS: begin
          tx_en_q <= 1'b1;
          case (tmr_q[1:0])
            2'd3: begin
              txd_q <= ~crc_in[7:0];
              fcs_q <= ~crc_in[31:8];
            end
            2'd2: txd_q <= fcs_q[7:0];
            2'd1: txd_q <= fcs_q[15:8];
            default: begin
              txd_q  <= fcs_q[23:16];
              done_q <= 1'b1;
            end
          endcase
          if (tmr_q == 16'd0) begin
            state_q <= IFG;
            tmr_q   <= IFG_LAST;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        IFG: begin
          if (tmr_q != 16'd0) begin
            tmr_q <= tmr_q - 16'd1;
          end else if (s.s_valid) begin
            // skip the IDLE bubble so back-to-back frames see exactly IFG_BYTES idle bytes
            state_q <= PRE;
            tmr_q   <= PRE_LAST;
          end else begin
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (s.s_valid && s.s_last) begin
            state_q <= IFG;
            tmr_q   <= IFG_LAST;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign frame_done = done_q;
  assign underrun   = urun_q;

endmodule
